rsm_controller: RTL and testbench

Multi-cycle control unit for the Simple RISC Machine datapath. It holds the instruction register (IR), PC and data-address register, decodes each instruction and drives every datapath control input from a Moore FSM. It also sequences the single-port synchronous RAM used for both instruction fetch and LDR/STR.

---
 rtl/rsm_pkg.sv | 68 ++++++
 rtl/rsm_instr_decoder.sv | 49 ++++
 rtl/rsm_controller.sv | 195 +++++++++++++++++++
 tb/tb_rsm_controller.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rsm_pkg.sv
// Shared encodings for the Simple RISC Machine controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package rsm_pkg;

    // FSM state encoding, kept as plain constants so older code can compare raw bits.
    typedef logic [4:0] state_t;
    localparam state_t S_RST  = 5'd0;
    localparam state_t S_IF1  = 5'd1;
    localparam state_t S_IF2  = 5'd2;
    localparam state_t S_UPD  = 5'd3;
    localparam state_t S_DEC  = 5'd4;
    localparam state_t S_GETA = 5'd5;
    localparam state_t S_GETB = 5'd6;
    localparam state_t S_EXEC = 5'd7;
    localparam state_t S_WREG = 5'd8;
    localparam state_t S_WIMM = 5'd9;
    localparam state_t S_ADDR = 5'd10;
    localparam state_t S_LADR = 5'd11;
    localparam state_t S_MRD1 = 5'd12;
    localparam state_t S_MRD2 = 5'd13;
    localparam state_t S_GETD = 5'd14;
    localparam state_t S_PASS = 5'd15;
    localparam state_t S_MWR  = 5'd16;
    localparam state_t S_HALT = 5'd17;

    // Opcode field IR[15:13]
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    // op field IR[12:11]
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;
    localparam logic [1:0] OP_MEM  = 2'b00;

    // RAM commands
    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    // One-hot writeback select
    localparam logic [3:0] VSEL_NONE  = 4'b0000;
    localparam logic [3:0] VSEL_MDATA = 4'b0001;
    localparam logic [3:0] VSEL_IMM   = 4'b0010;
    localparam logic [3:0] VSEL_PC    = 4'b0100;
    localparam logic [3:0] VSEL_C     = 4'b1000;

    // Instruction class; ADD and AND share a path, differing only in ALUop.
    typedef enum logic [3:0] {
        IC_NOP  = 4'd0,
        IC_MOVI = 4'd1,
        IC_MOVR = 4'd2,
        IC_ALU  = 4'd3,
        IC_CMP  = 4'd4,
        IC_MVN  = 4'd5,
        IC_LDR  = 4'd6,
        IC_STR  = 4'd7,
        IC_HALT = 4'd8
    } instr_class_t;

endpackage

// File: rtl/rsm_instr_decoder.sv
// Splits the instruction register into fields, immediates and an instruction class.
// Latency: combinational.
// Backpressure: none.
// Ports: ir in; op/rn/rd/sh/rm fields, sximm8/sximm5 sign-extended immediates, iclass out.
module rsm_instr_decoder
    import rsm_pkg::*;
(
    input  logic [15:0]   ir,
    output logic [1:0]    op,
    output logic [2:0]    rn,
    output logic [2:0]    rd,
    output logic [1:0]    sh,
    output logic [2:0]    rm,
    output logic [15:0]   sximm8,
    output logic [15:0]   sximm5,
    output instr_class_t  iclass
);

    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};

    // Unrecognised encodings fall through to NOP.
    always_comb begin
        iclass = IC_NOP;
        case (ir[15:13])
            OPC_MOV: begin
                if (op == OP_MOVI)      iclass = IC_MOVI;
                else if (op == OP_MOVR) iclass = IC_MOVR;
            end
            OPC_ALU: begin
                case (op)
                    OP_ADD, OP_AND: iclass = IC_ALU;
                    OP_CMP:         iclass = IC_CMP;
                    default:        iclass = IC_MVN;
                endcase
            end
            OPC_LDR:  if (op == OP_MEM) iclass = IC_LDR;
            OPC_STR:  if (op == OP_MEM) iclass = IC_STR;
            OPC_HALT: iclass = IC_HALT;
            default:  iclass = IC_NOP;
        endcase
    end

endmodule

// File: rtl/rsm_controller.sv
// Multi-cycle Moore controller for the Simple RISC Machine: fetch, decode, datapath and RAM sequencing.
// Latency: 5-10 cycles per instruction (MOVi 5, MOVr/MVN/CMP 7, ADD/AND 8, LDR 9, STR 10).
// Backpressure: none; the RAM has fixed one-cycle read latency, so the FSM never stalls.
// Ports: clk/reset; mem_rdata, datapath_out in; mem_cmd/mem_addr/mem_wdata to RAM;
//        PC, register-file, load strobes, selects, ALU/shift controls, immediates to datapath; halted status.
module rsm_controller
    import rsm_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] PC_RESET = '0
)(
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     mem_rdata,
    input  logic [15:0]     datapath_out,
    output logic [1:0]      mem_cmd,
    output logic [PC_W-1:0] mem_addr,
    output logic [15:0]     mem_wdata,
    output logic [PC_W-1:0] PC,
    output logic [2:0]      readnum,
    output logic [2:0]      writenum,
    output logic            write,
    output logic            loada,
    output logic            loadb,
    output logic            loadc,
    output logic            loads,
    output logic            asel,
    output logic            bsel,
    output logic            sximmsel,
    output logic [3:0]      vsel,
    output logic [1:0]      shift,
    output logic [1:0]      ALUop,
    output logic [15:0]     sximm8,
    output logic [15:0]     sximm5,
    output logic            halted
);

    state_t          state, state_nxt;
    logic [15:0]     ir;
    logic [PC_W-1:0] dat_addr;
    logic            addr_sel;

    logic [1:0]      op, sh;
    logic [2:0]      rn, rd, rm;
    instr_class_t    iclass;

    rsm_instr_decoder u_dec (
        .ir     (ir),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .sximm8 (sximm8),
        .sximm5 (sximm5),
        .iclass (iclass)
    );

    // Only the low PC_W bits of C form a RAM address.
    generate
        if (PC_W < 16) begin : g_dp_hi
            logic unused_dp_hi;
            assign unused_dp_hi = ^datapath_out[15:PC_W];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_RST;
            PC       <= PC_RESET;
            ir       <= '0;
            dat_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IF2)  ir       <= mem_rdata;
            if (state == S_UPD)  PC       <= PC + PC_W'(1);
            if (state == S_LADR) dat_addr <= datapath_out[PC_W-1:0];
        end
    end

    // IR only changes in IF2, so iclass is stable for the rest of the instruction.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RST:  state_nxt = S_IF1;
            S_IF1:  state_nxt = S_IF2;
            S_IF2:  state_nxt = S_UPD;
            S_UPD:  state_nxt = S_DEC;
            S_DEC: begin
                case (iclass)
                    IC_MOVI:                        state_nxt = S_WIMM;
                    IC_MOVR, IC_MVN:                state_nxt = S_GETB;
                    IC_ALU, IC_CMP, IC_LDR, IC_STR: state_nxt = S_GETA;
                    IC_HALT:                        state_nxt = S_HALT;
                    default:                        state_nxt = S_IF1;
                endcase
            end
            S_GETA: state_nxt = (iclass == IC_LDR || iclass == IC_STR) ? S_ADDR : S_GETB;
            S_GETB: state_nxt = S_EXEC;
            S_EXEC: state_nxt = (iclass == IC_CMP) ? S_IF1 : S_WREG;
            S_WREG: state_nxt = S_IF1;
            S_WIMM: state_nxt = S_IF1;
            S_ADDR: state_nxt = S_LADR;
            S_LADR: state_nxt = (iclass == IC_LDR) ? S_MRD1 : S_GETD;
            S_MRD1: state_nxt = S_MRD2;
            S_MRD2: state_nxt = S_IF1;
            S_GETD: state_nxt = S_PASS;
            S_PASS: state_nxt = S_MWR;
            S_MWR:  state_nxt = S_IF1;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_RST;
        endcase
    end

    always_comb begin
        mem_cmd  = MEM_NONE;
        addr_sel = 1'b1;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        sximmsel = 1'b0;
        vsel     = VSEL_NONE;
        shift    = 2'b00;
        ALUop    = 2'b00;
        halted   = 1'b0;
        case (state)
            S_IF1, S_IF2: mem_cmd = MEM_READ;
            S_GETA: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GETB: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                shift = sh;
                // MOVr and MVN only use B; zeroing A lets MOVr pass B through the adder.
                asel  = (iclass == IC_MOVR || iclass == IC_MVN);
                ALUop = (iclass == IC_MOVR) ? 2'b00 : op;
                loads = (iclass == IC_CMP);
                loadc = (iclass != IC_CMP);
            end
            S_WREG: begin
                vsel     = VSEL_C;
                writenum = rd;
                write    = 1'b1;
            end
            S_WIMM: begin
                vsel     = VSEL_IMM;
                writenum = rn;
                write    = 1'b1;
            end
            S_ADDR: begin
                bsel  = 1'b1;
                loadc = 1'b1;
            end
            S_MRD1: begin
                addr_sel = 1'b0;
                mem_cmd  = MEM_READ;
            end
            S_MRD2: begin
                addr_sel = 1'b0;
                mem_cmd  = MEM_READ;
                vsel     = VSEL_MDATA;
                writenum = rd;
                write    = 1'b1;
            end
            S_GETD: begin
                readnum = rd;
                loadb   = 1'b1;
            end
            S_PASS: begin
                asel  = 1'b1;
                loadc = 1'b1;
            end
            S_MWR: begin
                addr_sel = 1'b0;
                mem_cmd  = MEM_WRITE;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr  = addr_sel ? PC : dat_addr;
    assign mem_wdata = datapath_out;

endmodule

// File: tb/tb_rsm_controller.sv
// Bench for rsm_controller with a behavioural RAM and datapath around it.
// Latency: n/a.
// Backpressure: n/a.
module tb_rsm_controller;

    localparam int PC_W   = 8;
    localparam int EV_REG = 0;
    localparam int EV_MEM = 1;
    localparam int EV_STAT = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [15:0]     mem_rdata;
    logic [15:0]     rc;
    logic [1:0]      mem_cmd;
    logic [PC_W-1:0] mem_addr;
    logic [15:0]     mem_wdata;
    logic [PC_W-1:0] PC;
    logic [2:0]      readnum, writenum;
    logic            write, loada, loadb, loadc, loads, asel, bsel, sximmsel;
    logic [3:0]      vsel;
    logic [1:0]      shift, ALUop;
    logic [15:0]     sximm8, sximm5;
    logic            halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rsm_controller #(.PC_W(PC_W), .PC_RESET(8'h00)) dut (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .datapath_out(rc),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .PC(PC),
        .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .sximmsel(sximmsel), .vsel(vsel),
        .shift(shift), .ALUop(ALUop), .sximm8(sximm8), .sximm5(sximm5),
        .halted(halted)
    );

    // Behavioural RAM: one-cycle read latency.
    logic [15:0] ram [256];
    always @(posedge clk) begin
        if (mem_cmd == 2'b01)      mem_rdata <= ram[mem_addr];
        else if (mem_cmd == 2'b10) ram[mem_addr] <= mem_wdata;
    end

    // Behavioural datapath: register file, A/B/C, shifter, ALU, Z flag.
    logic [15:0] rf [8];
    logic [15:0] ra, rb, bsh, ain, bin, alu_out, wb, rd_dat;
    logic        zflag;
    assign rd_dat = rf[readnum];
    always_comb begin
        case (shift)
            2'b00:   bsh = rb;
            2'b01:   bsh = {rb[14:0], 1'b0};
            2'b10:   bsh = {1'b0, rb[15:1]};
            default: bsh = {rb[15], rb[15:1]};
        endcase
        ain = asel ? 16'd0 : ra;
        bin = bsel ? sximm5 : bsh;
        case (ALUop)
            2'b00:   alu_out = ain + bin;
            2'b01:   alu_out = ain - bin;
            2'b10:   alu_out = ain & bin;
            default: alu_out = ~bin;
        endcase
        case (vsel)
            4'b0001: wb = mem_rdata;
            4'b0010: wb = sximm8;
            4'b0100: wb = {8'h00, PC};
            default: wb = rc;
        endcase
    end
    always @(posedge clk) begin
        if (write) rf[writenum] <= wb;
        if (loada) ra <= rd_dat;
        if (loadb) rb <= rd_dat;
        if (loadc) rc <= alu_out;
        if (loads) zflag <= (alu_out == 16'd0);
    end

    typedef struct {
        int          kind;
        logic [15:0] num;
        logic [15:0] data;
        logic [3:0]  vs;
    } evt_t;

    typedef struct {
        logic [15:0] instr;
        int          cycles;
        evt_t        ev;
    } vec_t;

    evt_t sb_q[$];
    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic sb_check(input int kind, input logic [15:0] num, input logic [15:0] data,
                            input logic [3:0] vs, input string nm);
        evt_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected: got num=%0h data=%0h, expected no event", nm, num, data);
        end else begin
            e = sb_q.pop_front();
            chk({nm, "_kind"}, kind, e.kind);
            chk({nm, "_num"},  num,  e.num);
            chk({nm, "_data"}, data, e.data);
            chk({nm, "_vsel"}, vs,   e.vs);
        end
    endtask

    // Architectural-event monitor; register-file reads must never see the PC bypass.
    always @(negedge clk) begin
        if (!reset) begin
            if (write)             sb_check(EV_REG, {13'd0, writenum}, wb, vsel, "regwr");
            if (mem_cmd == 2'b10)  sb_check(EV_MEM, {8'd0, mem_addr}, mem_wdata, 4'b0000, "memwr");
            if (loads)             sb_check(EV_STAT, 16'd0, alu_out, 4'b0000, "status");
            if (loada || loadb)    chk("vsel2_on_read", {31'd0, vsel[2]}, 32'd0);
        end
    end

    // Entered at the falling edge inside IF1 of instruction i; leaves at the falling edge inside the next state.
    task automatic run_instr(input int i, input int ncyc, input bit push);
        if (push) sb_q.push_back(vecs[i].ev);
        for (int c = 0; c < ncyc; c++) begin
            if (c == 0) begin
                chk("fetch_cmd", mem_cmd, 2'b01);
                chk("fetch_addr", mem_addr, i);
            end
            if (c == 1) chk("fetch2_cmd", mem_cmd, 2'b01);
            if (c == 2) chk("upd_cmd", mem_cmd, 2'b00);
            if (c == 3) chk("pc_inc", PC, i + 1);
            if (i == 0 && c == 4) begin
                chk("movi_sximm8", sximm8, 16'h0007);
                chk("movi_vsel", vsel, 4'b0010);
            end
            if (i == 2 && c == 6) begin
                chk("add_shift", shift, 2'b01);
                chk("add_loadc", loadc, 1'b1);
                chk("add_bsel", bsel, 1'b0);
            end
            if (i == 3 && c == 6) begin
                chk("cmp_loads", loads, 1'b1);
                chk("cmp_loadc", loadc, 1'b0);
            end
            if (i == 4 && c == 5) begin
                chk("addr_bsel", bsel, 1'b1);
                chk("addr_sximmsel", sximmsel, 1'b0);
            end
            if (i == 4 && (c == 7 || c == 8)) begin
                chk("ldr_rd_cmd", mem_cmd, 2'b01);
                chk("ldr_rd_addr", mem_addr, 8'h08);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'hD007, 5,  '{EV_REG,  16'd0, 16'h0007, 4'b0010}};  // MOVi R0,#7
        vecs[1] = '{16'hD102, 5,  '{EV_REG,  16'd1, 16'h0002, 4'b0010}};  // MOVi R1,#2
        vecs[2] = '{16'hA049, 8,  '{EV_REG,  16'd2, 16'h000B, 4'b1000}};  // ADD R2,R0,R1,LSL#1
        vecs[3] = '{16'hA800, 7,  '{EV_STAT, 16'd0, 16'h0000, 4'b0000}};  // CMP R0,R0
        vecs[4] = '{16'h6061, 9,  '{EV_REG,  16'd3, 16'hBEEF, 4'b0001}};  // LDR R3,[R0,#1]
        vecs[5] = '{16'h8062, 10, '{EV_MEM,  16'd9, 16'hBEEF, 4'b0000}};  // STR R3,[R0,#2]
        vecs[6] = '{16'hB881, 7,  '{EV_REG,  16'd4, 16'hFFFD, 4'b1000}};  // MVN R4,R1

        for (int a = 0; a < 256; a++) ram[a] = 16'h0000;
        for (int r = 0; r < 8; r++) rf[r] = 16'h0000;
        ra = '0; rb = '0; rc = '0; zflag = 1'b0; mem_rdata = '0;
        for (int k = 0; k < 7; k++) ram[k] = vecs[k].instr;
        ram[7] = 16'hE000;  // HALT
        ram[8] = 16'hBEEF;

        // Held in reset.
        repeat (3) @(negedge clk);
        chk("rst_cmd", mem_cmd, 2'b00);
        chk("rst_pc", PC, 8'h00);
        chk("rst_halted", halted, 1'b0);
        chk("rst_write", write, 1'b0);
        chk("rst_vsel", vsel, 4'b0000);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_instr(i, vecs[i].cycles, 1'b1);

        // HALT: fetch/decode, then frozen.
        run_instr(7, 4, 1'b0);
        for (int c = 0; c < 20; c++) begin
            chk("halt_flag", halted, 1'b1);
            chk("halt_pc", PC, 8'h08);
            chk("halt_cmd", mem_cmd, 2'b00);
            @(negedge clk);
        end

        // Asynchronous reset out of HALT, checked before the next rising edge.
        #2 reset = 1'b1;
        #1;
        chk("arst_halted", halted, 1'b0);
        chk("arst_pc", PC, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_instr(i, vecs[i].cycles, 1'b1);
        run_instr(4, 7, 1'b0);  // stop inside MRD1
        chk("mrd1_cmd", mem_cmd, 2'b01);
        chk("mrd1_addr", mem_addr, 8'h08);
        #2 reset = 1'b1;
        #1;
        chk("abort_cmd", mem_cmd, 2'b00);
        chk("abort_pc", PC, 8'h00);
        chk("abort_write", write, 1'b0);
        chk("abort_addr", mem_addr, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_instr(0, vecs[0].cycles, 1'b1);

        chk("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
